// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with Z/N/C condition-code register and iterative shifter
//   Ports:
//     i_clk, i_reset        clock (rising edge), asynchronous active-high reset
//     i_valid / o_ready     op handshake; o_ready drops while a shift is in flight
//     i_op                  000 NOP, 001 NOT, 010 ADD, 011 SUB, 100 AND, 101 OR, 110 SHL, 111 SHR
//     i_data_1, i_data_2    source operand, destination operand / shift amount
//     i_flush               abort in-flight op and drop a same-cycle accept
//     i_flag_restore        load CCR from i_flags {Z,N,C}
//     o_valid               one-cycle pulse with o_result/o_flags
//     o_result, o_flags     result (held between pulses), CCR {Z,N,C}
module alu_seq #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 5
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_data_1,
    input  logic [WIDTH-1:0] i_data_2,
    input  logic             i_flush,
    input  logic             i_flag_restore,
    input  logic [2:0]       i_flags,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_result,
    output logic [2:0]       o_flags
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    localparam logic [2:0] OP_NOP = 3'b000, OP_NOT = 3'b001, OP_ADD = 3'b010, OP_SUB = 3'b011,
                           OP_AND = 3'b100, OP_OR  = 3'b101;
    state_t             state;
    logic [WIDTH-1:0]   sh_val;
    logic [SHAMT_W-1:0] cnt;
    logic               sh_dir;
    logic [WIDTH:0]     sum, diff;
    logic [WIDTH-1:0]   res_1, sh_next;
    logic               c_1, upd_c, sh_out, accept, is_shift;
    logic [SHAMT_W-1:0] shamt;
    function automatic logic [2:0] ccr(input logic [WIDTH-1:0] r, input logic c);
        return {r == '0, r[WIDTH-1], c};
    endfunction
    assign sum      = {1'b0, i_data_1} + {1'b0, i_data_2};
    assign diff     = {1'b0, i_data_2} - {1'b0, i_data_1};
    assign shamt    = i_data_2[SHAMT_W-1:0];
    assign accept   = i_valid & o_ready & ~i_flush;
    assign is_shift = i_op[2:1] == 2'b11;
    assign upd_c    = i_op == OP_ADD || i_op == OP_SUB || is_shift;
    // A zero-length shift is single-cycle: result is d1 and C is cleared.
    always_comb begin
        res_1 = i_op == OP_NOT ? ~i_data_1 :
                i_op == OP_ADD ? sum[WIDTH-1:0] :
                i_op == OP_SUB ? diff[WIDTH-1:0] :
                i_op == OP_AND ? i_data_1 & i_data_2 :
                i_op == OP_OR  ? i_data_1 | i_data_2 : i_data_1;
        c_1   = i_op == OP_ADD ? sum[WIDTH] : i_op == OP_SUB ? diff[WIDTH] : 1'b0;
    end
    // One-bit shift step; sh_dir=1 is a right shift.
    assign sh_next = sh_dir ? sh_val >> 1 : sh_val << 1;
    assign sh_out  = sh_dir ? sh_val[0] : sh_val[WIDTH-1];
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state    <= IDLE;
            o_ready  <= 1'b1;
            o_valid  <= 1'b0;
            o_result <= '0;
            o_flags  <= '0;
            cnt      <= '0;
            sh_val   <= '0;
            sh_dir   <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            case (state)
                SHIFT: begin
                    if (i_flush) begin
                        state   <= IDLE;
                        o_ready <= 1'b1;
                    end else begin
                        sh_val <= sh_next;
                        cnt    <= cnt - 1'b1;
                        if (cnt == 1) begin
                            state    <= DONE;
                            o_ready  <= 1'b1;
                            o_valid  <= 1'b1;
                            o_result <= sh_next;
                            o_flags  <= ccr(sh_next, sh_out);
                        end
                    end
                end
                IDLE, DONE: begin
                    if (!accept) begin
                        state <= IDLE;
                    end else if (is_shift && shamt != '0) begin
                        state   <= SHIFT;
                        o_ready <= 1'b0;
                        sh_val  <= i_data_1;
                        cnt     <= shamt;
                        sh_dir  <= i_op[0];
                    end else begin
                        state    <= DONE;
                        o_valid  <= 1'b1;
                        o_result <= res_1;
                        if (i_op != OP_NOP)
                            o_flags <= ccr(res_1, upd_c ? c_1 : o_flags[0]);
                    end
                end
                default: begin
                    state   <= IDLE;
                    o_ready <= 1'b1;
                end
            endcase
            // Restore overrides any op update on the same edge.
            if (i_flag_restore)
                o_flags <= i_flags;
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq
module tb_alu_seq;
    logic        i_clk = 1'b0, i_reset = 1'b1, i_valid = 1'b0, i_flush = 1'b0, i_flag_restore = 1'b0;
    logic [2:0]  i_op = 3'b000, i_flags = 3'b000;
    logic [15:0] i_data_1 = '0, i_data_2 = '0;
    logic        o_ready, o_valid;
    logic [15:0] o_result;
    logic [2:0]  o_flags;
    int          tests = 0, fails = 0;

    alu_seq #(.WIDTH(16), .SHAMT_W(5)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
        .i_op(i_op), .i_data_1(i_data_1), .i_data_2(i_data_2), .i_flush(i_flush),
        .i_flag_restore(i_flag_restore), .i_flags(i_flags), .o_valid(o_valid),
        .o_result(o_result), .o_flags(o_flags)
    );

    always #5 i_clk = ~i_clk;

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [15:0] d1, input logic [15:0] d2);
        i_valid = 1'b1; i_op = op; i_data_1 = d1; i_data_2 = d2;
    endtask

    task automatic check_out(input string name, input logic v, input logic [15:0] r, input logic [2:0] f);
        tests++;
        if (o_valid !== v || o_result !== r || o_flags !== f) begin
            fails++;
            $display("FAIL %s: got valid=%b result=%h flags=%b, expected valid=%b result=%h flags=%b",
                     name, o_valid, o_result, o_flags, v, r, f);
        end
    endtask

    task automatic test_reset();
        repeat (2) step();
        tests++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_result !== 16'h0 || o_flags !== 3'b000) begin
            fails++;
            $display("FAIL reset: got ready=%b valid=%b result=%h flags=%b, expected 1 0 0000 000",
                     o_ready, o_valid, o_result, o_flags);
        end
        i_reset = 1'b0;
        step();
    endtask

    task automatic test_one_cycle();
        drive(3'b010, 16'hFFFF, 16'h0001); step(); i_valid = 1'b0;
        check_out("add_wrap", 1'b1, 16'h0000, 3'b101);
        step();
        check_out("add_pulse_held", 1'b0, 16'h0000, 3'b101);
        drive(3'b011, 16'h0005, 16'h0003); step(); i_valid = 1'b0;
        check_out("sub_borrow", 1'b1, 16'hFFFE, 3'b011);
        drive(3'b100, 16'h0F0F, 16'h00FF); step(); i_valid = 1'b0;
        check_out("and_keeps_c", 1'b1, 16'h000F, 3'b001);
        drive(3'b001, 16'h00FF, 16'h0000); step(); i_valid = 1'b0;
        check_out("not", 1'b1, 16'hFF00, 3'b011);
        drive(3'b000, 16'h0000, 16'h1111); step(); i_valid = 1'b0;
        check_out("nop_keeps_ccr", 1'b1, 16'h0000, 3'b011);
        drive(3'b010, 16'h1234, 16'h1111); step(); i_valid = 1'b0;
        check_out("add_no_carry", 1'b1, 16'h2345, 3'b000);
        step();
    endtask

    task automatic test_shl();
        drive(3'b110, 16'h8888, 16'd5); step(); i_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (o_ready !== 1'b0 || o_valid !== 1'b0) begin
                fails++;
                $display("FAIL shl_stall[%0d]: got ready=%b valid=%b, expected 0 0", i, o_ready, o_valid);
            end
            step();
        end
        check_out("shl_result", 1'b1, 16'h1100, 3'b001);
        tests++;
        if (o_ready !== 1'b1) begin
            fails++;
            $display("FAIL shl_ready_done: got %b expected 1", o_ready);
        end
        step();
    endtask

    // Issues a shift and waits (bounded) for completion, checking latency and result.
    task automatic run_shift(input string name, input logic [2:0] op, input logic [15:0] d1,
                             input logic [15:0] d2, input logic [15:0] r, input logic [2:0] f);
        int n;
        drive(op, d1, d2); step(); i_valid = 1'b0;
        n = 1;
        while (!o_valid && n < 40) begin step(); n++; end
        tests++;
        if (n != int'(d2[4:0]) + 1) begin
            fails++;
            $display("FAIL %s_latency: got %0d cycles expected %0d", name, n, int'(d2[4:0]) + 1);
        end
        check_out(name, 1'b1, r, f);
        step();
    endtask

    task automatic test_shift_edges();
        run_shift("shl_zero", 3'b110, 16'h8001, 16'd0, 16'h8001, 3'b010);
        run_shift("shr_width", 3'b111, 16'h8000, 16'd16, 16'h0000, 3'b101);
        run_shift("shl_over", 3'b110, 16'hFFFF, 16'd17, 16'h0000, 3'b100);
        run_shift("shr_3", 3'b111, 16'h00F4, 16'd3, 16'h001E, 3'b001);
    endtask

    task automatic test_back_to_back();
        drive(3'b111, 16'h0003, 16'd1); step(); i_valid = 1'b0;
        tests++;
        if (o_ready !== 1'b0) begin
            fails++;
            $display("FAIL b2b_stall: got ready=%b expected 0", o_ready);
        end
        step();
        check_out("b2b_shr", 1'b1, 16'h0001, 3'b001);
        drive(3'b101, 16'h00F0, 16'h000F); step(); i_valid = 1'b0;
        check_out("b2b_or", 1'b1, 16'h00FF, 3'b001);
        step();
        check_out("b2b_idle", 1'b0, 16'h00FF, 3'b001);
    endtask

    task automatic test_flush();
        int seen;
        drive(3'b110, 16'h00FF, 16'd8); step(); i_valid = 1'b0;
        step();
        i_flush = 1'b1; step(); i_flush = 1'b0;
        check_out("flush_abort", 1'b0, 16'h00FF, 3'b001);
        tests++;
        if (o_ready !== 1'b1) begin
            fails++;
            $display("FAIL flush_ready: got %b expected 1", o_ready);
        end
        seen = 0;
        repeat (10) begin step(); if (o_valid) seen++; end
        tests++;
        if (seen != 0) begin
            fails++;
            $display("FAIL flush_no_valid: got %0d pulses expected 0", seen);
        end
        drive(3'b010, 16'h0001, 16'h0001); i_flush = 1'b1; i_flag_restore = 1'b1; i_flags = 3'b110;
        step(); i_valid = 1'b0; i_flush = 1'b0; i_flag_restore = 1'b0;
        check_out("flush_drop_restore", 1'b0, 16'h00FF, 3'b110);
        step();
    endtask

    task automatic test_restore();
        drive(3'b010, 16'h0001, 16'h0001); i_flag_restore = 1'b1; i_flags = 3'b101;
        step(); i_valid = 1'b0; i_flag_restore = 1'b0;
        check_out("restore_wins", 1'b1, 16'h0002, 3'b101);
        step();
    endtask

    task automatic test_reset_mid_shift();
        drive(3'b110, 16'h1234, 16'd10); step(); i_valid = 1'b0;
        step(); step();
        #2 i_reset = 1'b1;
        #1;
        tests++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_result !== 16'h0 || o_flags !== 3'b000) begin
            fails++;
            $display("FAIL reset_mid_shift: got ready=%b valid=%b result=%h flags=%b, expected 1 0 0000 000",
                     o_ready, o_valid, o_result, o_flags);
        end
        step(); i_reset = 1'b0;
        repeat (12) step();
        check_out("post_reset_quiet", 1'b0, 16'h0000, 3'b000);
    endtask

    initial begin
        test_reset();
        test_one_cycle();
        test_shl();
        test_shift_edges();
        test_back_to_back();
        test_flush();
        test_restore();
        test_reset_mid_shift();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
